// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard receiver that turns arrow-key and WASD make/break codes into
// held-level movement commands for the player-rectangle draw stage.
// Raw PS/2 pins are synchronized and glitch-filtered. Frames are checked for
// odd parity and the stop bit, and a watchdog aborts stalled frames.
// Every received byte and every frame error is also exposed for debug.
module ps2_move_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       move_up,
  output logic       move_down,
  output logic       move_right,
  output logic       move_left,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // Held-key bit layout: arrows in [3:0], WASD in [7:4];
  // within each group the order is up, down, right, left.
  logic [1:0]     clk_sync_r;
  logic [1:0]     data_sync_r;
  logic [FCW-1:0] filt_cnt_r;
  logic           filt_r;
  logic           fall_r;
  rx_state_t      state_r;
  logic [2:0]     bit_cnt_r;
  logic [7:0]     shift_r;
  logic           par_r;
  logic [16:0]    wd_r;
  logic           ext_r;
  logic           brk_r;
  logic [7:0]     held_r;
  logic [3:0]     key_s;
  logic           good_s;

  // Map an (extended, byte) pair to {hit, held-bit index}.
  // Unmapped codes return hit = 0.
  function automatic logic [3:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [3:0] res;
    case ({ext, code})
      9'h175:  res = {1'b1, 3'd0};
      9'h172:  res = {1'b1, 3'd1};
      9'h174:  res = {1'b1, 3'd2};
      9'h16B:  res = {1'b1, 3'd3};
      9'h01D:  res = {1'b1, 3'd4};
      9'h01B:  res = {1'b1, 3'd5};
      9'h023:  res = {1'b1, 3'd6};
      9'h01C:  res = {1'b1, 3'd7};
      default: res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

  assign key_s  = key_lookup(ext_r, shift_r);
  // The stop bit must be 1, and the data bits plus the parity bit must hold an odd number of ones.
  assign good_s = data_sync_r[1] & ((^shift_r) ^ par_r);

  // Two-flop synchronizers for the asynchronous PS/2 pins; the bus idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Glitch filter on ps2_clk: the level follows only after FILTER_LEN differing samples; a 1->0 move strobes fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_cnt_r <= '0;
      filt_r     <= 1'b1;
      fall_r     <= 1'b0;
    end else if (clk_sync_r[1] == filt_r) begin
      filt_cnt_r <= '0;
      fall_r     <= 1'b0;
    end else if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
      filt_cnt_r <= '0;
      filt_r     <= clk_sync_r[1];
      fall_r     <= filt_r;
    end else begin
      filt_cnt_r <= filt_cnt_r + FCW'(1);
      fall_r     <= 1'b0;
    end
  end

  // Receiver FSM with watchdog and make/break decoder; held bits update in the same edge the byte is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      bit_cnt_r      <= 3'd0;
      shift_r        <= 8'h00;
      par_r          <= 1'b0;
      wd_r           <= 17'd0;
      ext_r          <= 1'b0;
      brk_r          <= 1'b0;
      held_r         <= 8'h00;
      scancode       <= 8'h00;
      scancode_valid <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      scancode_valid <= 1'b0;
      frame_err      <= 1'b0;
      if (state_r == ST_IDLE) begin
        wd_r <= 17'd0;
        if (fall_r && !data_sync_r[1]) begin
          state_r   <= ST_DATA;
          bit_cnt_r <= 3'd0;
        end else begin
          state_r <= ST_IDLE;
        end
      end else if (fall_r) begin
        wd_r <= 17'd0;
        case (state_r)
          ST_DATA: begin
            shift_r <= {data_sync_r[1], shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          ST_PARITY: begin
            par_r   <= data_sync_r[1];
            state_r <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
            if (good_s) begin
              scancode       <= shift_r;
              scancode_valid <= 1'b1;
              if (shift_r == 8'hE0) begin
                ext_r <= 1'b1;
              end else if (shift_r == 8'hF0) begin
                brk_r <= 1'b1;
              end else begin
                if (key_s[3]) begin
                  held_r[key_s[2:0]] <= ~brk_r;
                end
                ext_r <= 1'b0;
                brk_r <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext_r     <= 1'b0;
              brk_r     <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end else if (wd_r == 17'(TIMEOUT_CYCLES - 1)) begin
        // Stalled mid-frame: abort, report, and forget any pending prefix.
        frame_err <= 1'b1;
        state_r   <= ST_IDLE;
        wd_r      <= 17'd0;
        ext_r     <= 1'b0;
        brk_r     <= 1'b0;
      end else begin
        wd_r <= wd_r + 17'd1;
      end
    end
  end

  // Output register: each direction is the OR of its arrow and WASD held bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      move_up    <= 1'b0;
      move_down  <= 1'b0;
      move_right <= 1'b0;
      move_left  <= 1'b0;
    end else begin
      move_up    <= held_r[0] | held_r[4];
      move_down  <= held_r[1] | held_r[5];
      move_right <= held_r[2] | held_r[6];
      move_left  <= held_r[3] | held_r[7];
    end
  end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Self-checking bench for ps2_move_decoder. A key-level model tracks which
// keys are held and predicts the movement outputs, the scancode and the error pulses.
module tb_ps2_move_decoder;
  localparam int TO   = 2000;
  localparam int FLEN = 8;
  localparam int HALF = 20;

  logic clk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic move_up, move_down, move_right, move_left, scancode_valid, frame_err;
  logic [7:0] scancode;

  ps2_move_decoder #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .move_up(move_up), .move_down(move_down), .move_right(move_right), .move_left(move_left),
    .scancode(scancode), .scancode_valid(scancode_valid), .frame_err(frame_err));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0, valid_cnt = 0, err_cnt = 0, last_valid_cyc = 0, last_err_cyc = 0, up_rise_cyc = 0;
  int last_fall_cyc = 0;
  logic [7:0] last_code = 8'h00;
  logic up_prev = 1'b0;

  // Monitor: count pulses and timestamp events on the falling clk edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (scancode_valid) begin valid_cnt = valid_cnt + 1; last_code = scancode; last_valid_cyc = cyc; end
    if (frame_err) begin err_cnt = err_cnt + 1; last_err_cyc = cyc; end
    if (move_up && !up_prev) up_rise_cyc = cyc;
    up_prev = move_up;
  end

  // Key-level model: 8 keys (4 arrows, then W S D A), each held or released.
  bit m_held[8];
  bit m_ext, m_brk;

  function automatic int key_of(bit ext, logic [7:0] b);
    if (ext) begin
      if (b == 8'h75) return 0;
      if (b == 8'h72) return 1;
      if (b == 8'h74) return 2;
      if (b == 8'h6B) return 3;
    end else begin
      if (b == 8'h1D) return 4;
      if (b == 8'h1B) return 5;
      if (b == 8'h23) return 6;
      if (b == 8'h1C) return 7;
    end
    return -1;
  endfunction

  task automatic m_byte(input logic [7:0] b, input bit good);
    int k;
    if (!good) begin m_ext = 0; m_brk = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = key_of(m_ext, b);
      if (k >= 0) m_held[k] = !m_brk;
      m_ext = 0; m_brk = 0;
    end
  endtask

  function automatic logic [3:0] m_moves();
    logic [3:0] v;
    for (int d = 0; d < 4; d++) v[3-d] = m_held[d] | m_held[d+4];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_held[i] = 0;
    m_ext = 0; m_brk = 0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk); #1;
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    #1; ps2_clk = 1'b0; last_fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    #1; ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b);
    if (bad_par) p = ~p;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(!bad_stop);
    #1; ps2_data = 1'b1;
    repeat (40) @(negedge clk);
    m_byte(b, !bad_par && !bad_stop);
  endtask

  task automatic test_reset();
    checks++;
    if ({move_up, move_down, move_right, move_left, scancode, scancode_valid, frame_err} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", {move_up, move_down, move_right, move_left, scancode, scancode_valid, frame_err});
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    m_reset();
  endtask

  task automatic test_single_w();
    int v0;
    v0 = valid_cnt;
    send_frame(8'h1D, 0, 0);
    checks++;
    if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL w_valid_count got=%0d want=1", valid_cnt - v0); end
    checks++;
    if (last_code !== 8'h1D) begin errors++; $display("FAIL w_scancode got=%h want=1d", last_code); end
    checks++;
    if (up_rise_cyc - last_valid_cyc !== 1) begin errors++; $display("FAIL w_latency got=%0d want=1", up_rise_cyc - last_valid_cyc); end
    checks++;
    if ({move_up, move_down, move_right, move_left} !== m_moves()) begin
      errors++; $display("FAIL w_moves got=%b want=%b", {move_up, move_down, move_right, move_left}, m_moves());
    end
    send_frame(8'hF0, 0, 0); send_frame(8'h1D, 0, 0);
    checks++;
    if (move_up !== 1'b0) begin errors++; $display("FAIL w_release got=%b want=0", move_up); end
  endtask

  task automatic test_arrow_seq();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    checks++;
    if (move_up !== 1'b1) begin errors++; $display("FAIL arrow_make got=%b want=1", move_up); end
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    checks++;
    if (move_up !== 1'b0) begin errors++; $display("FAIL arrow_break got=%b want=0", move_up); end
    checks++;
    if (valid_cnt - v0 !== 5 || err_cnt != e0) begin
      errors++; $display("FAIL arrow_counts valid=%0d err=%0d want valid=5 err=0", valid_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_pair_hold();
    send_frame(8'h1D, 0, 0); send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'h1D, 0, 0);  // typematic repeat
    send_frame(8'hF0, 0, 0); send_frame(8'h1D, 0, 0);
    checks++;
    if (move_up !== 1'b1) begin errors++; $display("FAIL pair_one_held got=%b want=1", move_up); end
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    checks++;
    if (move_up !== 1'b0) begin errors++; $display("FAIL pair_both_released got=%b want=0", move_up); end
  endtask

  task automatic test_bad_parity();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1, 0);
    checks++;
    if (err_cnt - e0 !== 1 || valid_cnt != v0 || move_left !== 1'b0) begin
      errors++; $display("FAIL bad_parity err=%0d valid=%0d left=%b want 1 0 0", err_cnt - e0, valid_cnt - v0, move_left);
    end
    send_frame(8'h1C, 0, 0);
    checks++;
    if (move_left !== 1'b1) begin errors++; $display("FAIL good_after_bad got=%b want=1", move_left); end
  endtask

  task automatic test_timeout();
    int e0, dt;
    bit seen;
    e0 = err_cnt; seen = 0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < TO + 200 && !seen; i++) begin
      @(negedge clk);
      if (err_cnt != e0) seen = 1;
    end
    dt = last_err_cyc - last_fall_cyc;
    checks++;
    if (!seen || dt < TO || dt > TO + FLEN + 12) begin
      errors++; $display("FAIL timeout_delay seen=%0d got=%0d want=%0d..%0d", seen, dt, TO, TO + FLEN + 12);
    end
    m_byte(8'h00, 0);
    send_frame(8'h23, 0, 0);
    checks++;
    if (move_right !== 1'b1 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL timeout_recover right=%b errs=%0d want 1 1", move_right, err_cnt - e0);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h23, 8'h1C, 8'h75, 8'h72, 8'h74, 8'h6B, 8'h11, 8'h29};
    logic [7:0] b;
    bit bp, bs;
    int v0, e0;
    for (int n = 0; n < 40; n++) begin
      b  = pool[$urandom_range(11, 0)];
      bp = ($urandom_range(7, 0) == 0);
      bs = !bp && ($urandom_range(15, 0) == 0);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(b, bp, bs);
      checks++;
      if ((bp || bs) ? (err_cnt - e0 !== 1 || valid_cnt != v0)
                     : (valid_cnt - v0 !== 1 || err_cnt != e0 || last_code !== b)) begin
        errors++; $display("FAIL rand_frame byte=%h bad=%0d%0d valid=%0d err=%0d code=%h", b, bp, bs, valid_cnt - v0, err_cnt - e0, last_code);
      end
      checks++;
      if ({move_up, move_down, move_right, move_left} !== m_moves()) begin
        errors++; $display("FAIL rand_moves byte=%h got=%b want=%b", b, {move_up, move_down, move_right, move_left}, m_moves());
      end
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h1B, 0, 0);
    checks++;
    if (move_down !== 1'b1) begin errors++; $display("FAIL pre_reset_down got=%b want=1", move_down); end
    send_bit(1'b0); send_bit(1'b1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({move_up, move_down, move_right, move_left, scancode, scancode_valid, frame_err} !== 14'd0) begin
      errors++; $display("FAIL async_reset got=%h want=0", {move_up, move_down, move_right, move_left, scancode, scancode_valid, frame_err});
    end
    m_reset();
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h1B, 0, 0);
    checks++;
    if ({move_up, move_down, move_right, move_left} !== 4'b0100 || last_code !== 8'h1B) begin
      errors++; $display("FAIL after_reset moves=%b code=%h want 0100 1b", {move_up, move_down, move_right, move_left}, last_code);
    end
  endtask

  initial begin
    m_reset();
    #2;
    test_reset();
    test_single_w();
    test_arrow_seq();
    test_pair_hold();
    test_bad_parity();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
